concat_if_stream: RTL and testbench
===================================

Name: concat_if_stream

Overview:
- Streaming, parametrised successor to the combinational concat/if-else block.
- Each accepted beat carries three fields {a, b, c} and a condition bit. The block computes the full concatenation and a condition-selected result, then buffers both in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- It also keeps a saturating count of beats accepted with the condition set.
- Sits between a field-producing datapath and a downstream consumer that may apply backpressure.

Parameters:
- A_W, 4, width of field a
- B_W, 4, width of field b
- C_W, 8, width of field c, and width of the selected output
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 8, width of the condition-hit counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  A_W  field a
- in_b  in  B_W  field b
- in_c  in  C_W  field c
- in_cond  in  1  select condition
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts the head entry
- out_concat  out  A_W+B_W+C_W  {a,b,c} of the head entry
- out_sel  out  C_W  selected value of the head entry
- cnt_clr  in  1  synchronous clear of hit counter
- cnt_hit  out  CNT_W  saturating count of accepted beats with cond=1
- level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous, active-low.
- Reset values: while rst_n=0, all pointers, level and cnt_hit are 0; out_valid=0 and in_ready=1. Storage contents are not reset; out_concat and out_sel are don't-care while out_valid=0.
- Push: occurs on a clk edge where in_valid && in_ready. It writes:
  - concat = {in_a, in_b, in_c}
  - sel = in_cond ? in_c : ab_fit
- ab_fit: {in_a, in_b} resized to C_W.
  - If A_W+B_W < C_W, zero-extend on the MSB side.
  - If A_W+B_W > C_W, keep the low C_W bits.
  - If equal, pass through unchanged.
- Pop: occurs on a clk edge where out_valid && out_ready. The head advances.
- Latency: first-word latency is 1 cycle. A beat pushed at edge N is visible on out_* with out_valid=1 after edge N. No combinational input-to-output path.
- Ready/valid relationships:
  - in_ready = (level != DEPTH). It is a function of state only and never of in_valid.
  - out_valid = (level != 0).
  - out_concat and out_sel hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged and both succeed.
- Full (level = DEPTH): in_ready=0, so no push. A pop that cycle drops level to DEPTH-1, and in_ready rises the next cycle. No same-cycle bypass.
- Empty (level = 0): out_valid=0 and out_ready is ignored. A push that cycle makes level 1.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- cnt_hit:
  - Increments by 1 on each push with in_cond=1.
  - Saturates at 2^CNT_W-1 and holds.
  - cnt_clr=1 forces 0 the next edge; clear wins over a simultaneous increment.
- Reset mid-operation: asserting rst_n low empties the FIFO immediately, with all queued beats discarded. Outputs take their reset values asynchronously.

Optional Feature:
- Macro: CONCAT_IF_STREAM_PARITY_EN
- Defined:
  - Each entry additionally stores even parity (XOR reduction) of {concat, sel}.
  - New output port out_par (1 bit) shows the head entry's parity.
  - New input port in_par_inj (1 bit) inverts the stored parity bit on that push, for error injection.
- Not defined: neither port exists, and storage width is unchanged.

Decomposition:
- Package concat_if_pkg contains:
  - the function fit_width(value, target width) implementing the ab_fit rule
  - localparam helpers CONCAT_W = A_W+B_W+C_W and LVL_W = $clog2(DEPTH)+1, supplied as functions taking the parameters
- Sub-module concat_if_fifo:
  - generic DEPTH × WIDTH storage with pointer and level logic, plus full/empty
  - the top module instantiates it with WIDTH = CONCAT_W + C_W (+1 with parity)
  - the top module holds the select logic and the counter

Test Plan:
- Default params: push a=4'hA, b=4'h5, c=8'h3C, cond=0 with out_ready=1. Next cycle out_concat=16'hA53C, out_sel=8'hA5, out_valid=1. The following cycle out_valid=0.
- Same fields with cond=1: out_sel=8'h3C and cnt_hit=1. Then A_W=2, B_W=2: {2'b11, 2'b01} yields out_sel=8'h0D (zero-extend).
- out_ready=0, push 5 beats with DEPTH=4:
  - in_ready=0 after the 4th beat, level=4.
  - The 5th beat is held until one pop.
  - Beats then drain in order with wrap-around of the pointers.
- Level 2, push and pop on the same edge: level stays 2 and the order is preserved over 20 back-to-back cycles with random out_ready.
- CNT_W=3:
  - 9 cond=1 pushes leave cnt_hit=7 (saturated).
  - cnt_clr together with a cond=1 push gives cnt_hit=0.
- Level 3: assert rst_n=0 mid-cycle. out_valid drops immediately with level=0; after release, in_ready=1 and the first new beat appears with 1-cycle latency. With CONCAT_IF_STREAM_PARITY_EN, in_par_inj=1 yields an inverted out_par.

Source files
------------

// File: rtl/concat_if_pkg.sv
// concat_if_pkg: shared helpers for the concat_if_stream slice.
//   concat_w  - width of the {a,b,c} concatenation
//   lvl_w     - width of an occupancy counter able to hold 0..DEPTH
//   fit_width - resize a zero-extended value to a target width
//               (MSB zero-extension or low-bit truncation)
package concat_if_pkg;

  function automatic int unsigned concat_w(input int unsigned a_w,
                                           input int unsigned b_w,
                                           input int unsigned c_w);
    return a_w + b_w + c_w;
  endfunction

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Caller passes the value already zero-extended to 64 bits, so widening is
  // implicit; masking keeps only the low 'width' bits for the narrowing case.
  function automatic logic [63:0] fit_width(input logic [63:0]   value,
                                            input int unsigned   width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return value & mask;
  endfunction

endpackage

// File: rtl/concat_if_fifo.sv
// concat_if_fifo: generic DEPTH x WIDTH synchronous FIFO.
//   clk, rst_n         - clock, asynchronous active-low reset
//   wr_en / wr_data    - write request and data (ignored while full)
//   rd_en / rd_data    - read request (ignored while empty), head entry
//   full, empty, level - occupancy status
// Storage is not reset; pointers wrap modulo DEPTH (DEPTH is a power of two).
module concat_if_fifo
  import concat_if_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign level = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/concat_if_stream.sv
// concat_if_stream: streaming concat / condition-select block.
//   in_valid/in_ready, in_a/in_b/in_c, in_cond - input beat and handshake
//   out_valid/out_ready, out_concat, out_sel   - buffered head entry
//   cnt_clr, cnt_hit                           - saturating cond=1 push count
//   level                                      - FIFO occupancy
// Optional macro CONCAT_IF_STREAM_PARITY_EN adds in_par_inj (invert stored
// parity on push) and out_par (even parity of the head {concat, sel}).
module concat_if_stream
  import concat_if_pkg::*;
#(
  parameter int unsigned A_W   = 4,
  parameter int unsigned B_W   = 4,
  parameter int unsigned C_W   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [A_W-1:0]                    in_a,
  input  logic [B_W-1:0]                    in_b,
  input  logic [C_W-1:0]                    in_c,
  input  logic                              in_cond,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [concat_w(A_W,B_W,C_W)-1:0]  out_concat,
  output logic [C_W-1:0]                    out_sel,
  input  logic                              cnt_clr,
  output logic [CNT_W-1:0]                  cnt_hit,
`ifdef CONCAT_IF_STREAM_PARITY_EN
  input  logic                              in_par_inj,
  output logic                              out_par,
`endif
  output logic [lvl_w(DEPTH)-1:0]           level
);

  localparam int unsigned CONCAT_W = concat_w(A_W, B_W, C_W);
`ifdef CONCAT_IF_STREAM_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned ENTRY_W = CONCAT_W + C_W + PAR_W;

  logic [CONCAT_W-1:0] concat;
  logic [C_W-1:0]      ab_fit;
  logic [C_W-1:0]      sel;
  logic [ENTRY_W-1:0]  wr_data;
  logic [ENTRY_W-1:0]  rd_data;
  logic                full;
  logic                empty;
  logic                push;
  logic [CNT_W-1:0]    cnt_hit_q, cnt_hit_d;

  assign concat = {in_a, in_b, in_c};
  assign ab_fit = C_W'(fit_width(64'({in_a, in_b}), C_W));
  assign sel    = in_cond ? in_c : ab_fit;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;

`ifdef CONCAT_IF_STREAM_PARITY_EN
  assign wr_data = {(^{concat, sel}) ^ in_par_inj, concat, sel};
  assign {out_par, out_concat, out_sel} = rd_data;
`else
  assign wr_data = {concat, sel};
  assign {out_concat, out_sel} = rd_data;
`endif

  concat_if_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Clear has priority over a same-edge increment.
  always_comb begin
    cnt_hit_d = cnt_hit_q;
    if (cnt_clr) begin
      cnt_hit_d = '0;
    end else if (push && in_cond && (cnt_hit_q != '1)) begin
      cnt_hit_d = cnt_hit_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_hit_q <= '0;
    else        cnt_hit_q <= cnt_hit_d;
  end

  assign cnt_hit = cnt_hit_q;

endmodule

// File: tb/tb_concat_if_stream.sv
module tb_concat_if_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Default-parameter instance
  logic        in_valid, in_ready, in_cond, out_valid, out_ready, cnt_clr;
  logic [3:0]  in_a, in_b;
  logic [7:0]  in_c, out_sel, cnt_hit;
  logic [15:0] out_concat;
  logic [2:0]  level;
  logic        in_par_inj, out_par;

  // A_W=2, B_W=2, CNT_W=3: zero-extend select and counter saturation
  logic        d2_in_valid, d2_in_ready, d2_in_cond, d2_out_valid, d2_out_ready, d2_cnt_clr;
  logic [1:0]  d2_in_a, d2_in_b;
  logic [7:0]  d2_in_c, d2_out_sel;
  logic [11:0] d2_out_concat;
  logic [2:0]  d2_cnt_hit, d2_level;
  logic        d2_out_par;

  // C_W=4: truncating select
  logic        d3_in_valid, d3_in_ready, d3_in_cond, d3_out_valid, d3_out_ready, d3_cnt_clr;
  logic [3:0]  d3_in_a, d3_in_b, d3_in_c, d3_out_sel;
  logic [11:0] d3_out_concat;
  logic [7:0]  d3_cnt_hit;
  logic [2:0]  d3_level;
  logic        d3_out_par;

  concat_if_stream u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_concat(out_concat),
    .out_sel(out_sel), .cnt_clr(cnt_clr), .cnt_hit(cnt_hit),
`ifdef CONCAT_IF_STREAM_PARITY_EN
    .in_par_inj(in_par_inj), .out_par(out_par),
`endif
    .level(level)
  );

  concat_if_stream #(.A_W(2), .B_W(2), .C_W(8), .DEPTH(4), .CNT_W(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_a(d2_in_a), .in_b(d2_in_b), .in_c(d2_in_c), .in_cond(d2_in_cond),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_concat(d2_out_concat),
    .out_sel(d2_out_sel), .cnt_clr(d2_cnt_clr), .cnt_hit(d2_cnt_hit),
`ifdef CONCAT_IF_STREAM_PARITY_EN
    .in_par_inj(1'b0), .out_par(d2_out_par),
`endif
    .level(d2_level)
  );

  concat_if_stream #(.A_W(4), .B_W(4), .C_W(4), .DEPTH(4), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_a(d3_in_a), .in_b(d3_in_b), .in_c(d3_in_c), .in_cond(d3_in_cond),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_concat(d3_out_concat),
    .out_sel(d3_out_sel), .cnt_clr(d3_cnt_clr), .cnt_hit(d3_cnt_hit),
`ifdef CONCAT_IF_STREAM_PARITY_EN
    .in_par_inj(1'b0), .out_par(d3_out_par),
`endif
    .level(d3_level)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the default instance: queue of {concat, sel}
  logic [23:0] exp_q[$];
  int unsigned m_lvl = 0;
  int unsigned m_cnt = 0;

  task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] c, input logic cond, input logic rdy);
    logic [23:0] head;
    logic        do_push, do_pop;
    in_valid = v; in_a = a; in_b = b; in_c = c; in_cond = cond; out_ready = rdy;
    do_push = v && (m_lvl != 4);
    do_pop  = rdy && (m_lvl != 0);
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("head_concat", {48'd0, out_concat}, {48'd0, head[23:8]});
      check("head_sel", {56'd0, out_sel}, {56'd0, head[7:0]});
    end
    if (do_pop) head = exp_q.pop_front();
    if (do_push) begin
      exp_q.push_back({a, b, c, (cond ? c : {a, b})});
      if (cond && m_cnt != 255) m_cnt++;
    end
    m_lvl = exp_q.size();
    @(posedge clk); #1;
    check("level", 64'(level), 64'(m_lvl));
    check("in_ready", 64'(in_ready), 64'(m_lvl != 4));
    check("out_valid", 64'(out_valid), 64'(m_lvl != 0));
    check("cnt_hit", 64'(cnt_hit), 64'(m_cnt));
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_c = 0; in_cond = 0; out_ready = 0;
    cnt_clr = 0; in_par_inj = 0;
    d2_in_valid = 0; d2_in_a = 0; d2_in_b = 0; d2_in_c = 0; d2_in_cond = 0;
    d2_out_ready = 1; d2_cnt_clr = 0;
    d3_in_valid = 0; d3_in_a = 0; d3_in_b = 0; d3_in_c = 0; d3_in_cond = 0;
    d3_out_ready = 1; d3_cnt_clr = 0;

    #12;
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cnt_hit", 64'(cnt_hit), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic push, cond=0; side instances exercise the resize rule
    d2_in_valid = 1; d2_in_a = 2'b11; d2_in_b = 2'b01; d2_in_c = 8'hFF;
    d3_in_valid = 1; d3_in_a = 4'hA; d3_in_b = 4'h5; d3_in_c = 4'h3;
    cycle(1'b1, 4'hA, 4'h5, 8'h3C, 1'b0, 1'b1);
    d2_in_valid = 0; d3_in_valid = 0;
    check("basic_concat", 64'(out_concat), 64'hA53C);
    check("basic_sel", 64'(out_sel), 64'hA5);
    check("zext_sel", 64'(d2_out_sel), 64'h0D);
    check("zext_concat", 64'(d2_out_concat), 64'hDFF);
    check("trunc_sel", 64'(d3_out_sel), 64'h5);
    check("trunc_concat", 64'(d3_out_concat), 64'hA53);
    cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
    check("basic_drained", 64'(out_valid), 64'd0);

    // cond=1 selects c and counts
    cycle(1'b1, 4'hA, 4'h5, 8'h3C, 1'b1, 1'b1);
    check("cond_sel", 64'(out_sel), 64'h3C);
    check("cond_cnt", 64'(cnt_hit), 64'd1);
    cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);

    // Fill to full with out_ready=0; 5th beat is held
    for (int i = 0; i < 5; i++) begin
      logic [3:0] k;
      k = 4'(i);
      cycle(1'b1, k, ~k, 8'h10 + 8'(i), k[0], 1'b0);
    end
    check("full_level", 64'(level), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 4'd4, ~4'd4, 8'h14, 1'b0, 1'b1);
    cycle(1'b1, 4'd4, ~4'd4, 8'h14, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);

    // Level 2 with back-to-back push/pop
    cycle(1'b1, 4'h1, 4'h2, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 4'h4, 4'h5, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] k;
      logic       rdy;
      k = 4'(i + 7);
      rdy = (i < 5) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(1'b1, k, k ^ 4'h9, {k, ~k}, k[1], rdy);
      if (i < 5) check("steady_level2", 64'(level), 64'd2);
    end
    repeat (5) cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);

    // Counter saturation and clear priority on CNT_W=3 instance
    d2_in_valid = 1; d2_in_cond = 1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("cnt_saturated", 64'(d2_cnt_hit), 64'd7);
    d2_cnt_clr = 1;
    @(posedge clk); #1;
    check("cnt_clr_wins", 64'(d2_cnt_hit), 64'd0);
    d2_cnt_clr = 0; d2_in_valid = 0; d2_in_cond = 0;
    @(posedge clk); #1;

    // Asynchronous reset with 3 beats queued
    cycle(1'b1, 4'h1, 4'h1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 4'h2, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 4'h3, 4'h3, 8'h33, 1'b0, 1'b0);
    check("pre_rst_level", 64'(level), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_cnt", 64'(cnt_hit), 64'd0);
    exp_q.delete(); m_lvl = 0; m_cnt = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 4'h7, 4'h8, 8'h99, 1'b0, 1'b0);
    check("post_rst_concat", 64'(out_concat), 64'h7899);
    check("post_rst_sel", 64'(out_sel), 64'h78);
    cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);

`ifdef CONCAT_IF_STREAM_PARITY_EN
    in_par_inj = 1'b0;
    cycle(1'b1, 4'hA, 4'h5, 8'h3C, 1'b0, 1'b0);
    check("par_clean", 64'(out_par), 64'(^{16'hA53C, 8'hA5}));
    cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
    in_par_inj = 1'b1;
    cycle(1'b1, 4'hA, 4'h5, 8'h3C, 1'b0, 1'b0);
    in_par_inj = 1'b0;
    check("par_injected", 64'(out_par), 64'(~(^{16'hA53C, 8'hA5})));
    cycle(1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
